// File: rtl/huc_rtc_engine_if.sv
// Command/save/HPS bus of the HuC RTC engine; master = mapper/HPS side, slave = engine.
interface huc_rtc_engine_if;
  logic        ce_cpu;
  logic        cmd_wr;
  logic [7:0]  cmd_di;
  logic [3:0]  rd_data;
  logic [3:0]  rd_flags;
  logic        busy;
  logic [32:0] RTC_time;
  logic        bk_rtc_wr;
  logic [7:0]  bk_addr;
  logic [15:0] bk_data;
  logic [31:0] RTC_timestampOut;
  logic [47:0] RTC_savedtimeOut;
  logic        alarm_irq;

  modport master (
    output ce_cpu, cmd_wr, cmd_di, RTC_time, bk_rtc_wr, bk_addr, bk_data,
    input  rd_data, rd_flags, busy, RTC_timestampOut, RTC_savedtimeOut, alarm_irq
  );
  modport slave (
    input  ce_cpu, cmd_wr, cmd_di, RTC_time, bk_rtc_wr, bk_addr, bk_data,
    output rd_data, rd_flags, busy, RTC_timestampOut, RTC_savedtimeOut, alarm_irq
  );
endinterface

// File: rtl/huc_rtc_engine.sv
// HuC RTC engine: sec/min/day timekeeping, nibble command port, save load with minute-step catch-up.
// All outputs registered, commands visible next cycle, no backpressure; RTC_ALARM_EN adds the minute alarm.
module huc_rtc_engine #(
  parameter int CLK_DIV = 33554432,
  parameter int DAY_W   = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  huc_rtc_engine_if.slave  bus
);
  localparam int SUB_W = $clog2(CLK_DIV);
  localparam int DN    = DAY_W / 4;
  localparam int SVW   = 18 + DAY_W;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CATCHUP = 1'b1;
  localparam logic [SUB_W-1:0] SUB_ONE = 1;
  localparam logic [DAY_W-1:0] DAY_ONE = 1;

  logic [SUB_W-1:0] sub_q, sub_nx;
  logic [5:0]       sec_q, sec_nx;
  logic [11:0]      min_q, min_nx;
  logic [DAY_W-1:0] day_q, day_nx;
  logic [31:0]      ts_q, ts_nx, sv_ts_q, sv_ts_nx, diff_q, diff_nx;
  logic [SVW-1:0]   sv_time_q, sv_time_nx;
  logic [0:0]       state_q, state_nx;
  logic [7:0]       idx_q, idx_nx;
  logic [3:0]       rd_nib_q, rd_nib_nx, flags_q, flags_nx, rd_data_q, rd_val, opd, op;
  logic [47:0]      saved_q;
  logic             t32_q, t32_qq, busy_q, tick, toggle, cmd_en, load;

  function automatic logic [DAY_W+11:0] min_step(input logic [DAY_W-1:0] d, input logic [11:0] m);
    return (m >= 12'd1439) ? {d + DAY_ONE, 12'd0} : {d, m + 12'd1};
  endfunction

  function automatic logic [DAY_W+17:0] sec_step(input logic [DAY_W-1:0] d, input logic [11:0] m,
                                                input logic [5:0] s);
    return (s == 6'd59) ? {min_step(d, m), 6'd0} : {d, m, s + 6'd1};
  endfunction

  always_comb begin
    tick   = (sub_q == SUB_W'(CLK_DIV - 1));
    toggle = t32_q ^ t32_qq;
    cmd_en = bus.ce_cpu & bus.cmd_wr;
    op     = bus.cmd_di[7:4];
    opd    = bus.cmd_di[3:0];
    load   = bus.bk_rtc_wr && (bus.bk_addr == 8'd5);
    sub_nx = tick ? '0 : sub_q + SUB_ONE;
    sec_nx = sec_q;
    min_nx = min_q;
    day_nx = day_q;
    diff_nx  = diff_q;
    state_nx = state_q;
    ts_nx    = ts_q;
    sv_ts_nx   = sv_ts_q;
    sv_time_nx = sv_time_q;
    idx_nx     = idx_q;
    rd_nib_nx  = rd_nib_q;
    flags_nx   = flags_q;

    // A tick cycle stalls catch-up so the tick's second is never lost.
    if (tick) begin
      {day_nx, min_nx, sec_nx} = sec_step(day_q, min_q, sec_q);
      ts_nx = ts_q + 32'd1;
    end else if (state_q == CATCHUP) begin
      if (diff_q >= 32'd60) begin
        {day_nx, min_nx} = min_step(day_q, min_q);
        diff_nx = diff_q - 32'd60;
      end else begin
        {day_nx, min_nx, sec_nx} = sec_step(day_q, min_q, sec_q);
        diff_nx = diff_q - 32'd1;
      end
      if (diff_nx == '0) state_nx = IDLE;
    end
    if (toggle) ts_nx = bus.RTC_time[31:0];

    rd_val = 4'h0;
    for (int i = 0; i < 3; i++)  if (idx_q == 8'(i))     rd_val = min_q[i*4 +: 4];
    for (int i = 0; i < DN; i++) if (idx_q == 8'(i + 3)) rd_val = day_q[i*4 +: 4];

    if (cmd_en) begin
      case (op)
        4'h1: begin
          rd_nib_nx = rd_val;
          idx_nx    = idx_q + 8'd1;
        end
        4'h2, 4'h3: begin
          for (int i = 0; i < 3; i++)  if (idx_q == 8'(i))     min_nx[i*4 +: 4] = opd;
          for (int i = 0; i < DN; i++) if (idx_q == 8'(i + 3)) day_nx[i*4 +: 4] = opd;
          if (idx_q == 8'd0) begin
            sec_nx = '0;
            sub_nx = '0;
          end
          if (op == 4'h3) idx_nx = idx_q + 8'd1;
        end
        4'h4: idx_nx[3:0] = opd;
        4'h5: idx_nx[7:4] = opd;
        4'h6: flags_nx    = opd;
        default: ;
      endcase
    end

    if (bus.bk_rtc_wr) begin
      if (bus.bk_addr == 8'd0) sv_ts_nx[15:0]  = bus.bk_data;
      if (bus.bk_addr == 8'd1) sv_ts_nx[31:16] = bus.bk_data;
      for (int b = 0; b < SVW; b++)
        if (bus.bk_addr == 8'(2 + b / 16)) sv_time_nx[b] = bus.bk_data[b % 16];
    end

    if (load) begin
      sec_nx   = sv_time_q[5:0];
      min_nx   = sv_time_q[17:6];
      day_nx   = sv_time_q[18 +: DAY_W];
      diff_nx  = (ts_q > sv_ts_q) ? ts_q - sv_ts_q : '0;
      state_nx = (diff_nx != '0) ? CATCHUP : IDLE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sub_q <= '0;  sec_q <= '0;  min_q <= '0;  day_q <= '0;
      ts_q <= '0;   sv_ts_q <= '0; sv_time_q <= '0; diff_q <= '0;
      state_q <= IDLE; idx_q <= '0; rd_nib_q <= '0; flags_q <= '0;
      rd_data_q <= '0; saved_q <= '0; busy_q <= 1'b0;
      t32_q <= 1'b0; t32_qq <= 1'b0;
    end else begin
      sub_q <= sub_nx;  sec_q <= sec_nx;  min_q <= min_nx;  day_q <= day_nx;
      ts_q <= ts_nx;    sv_ts_q <= sv_ts_nx; sv_time_q <= sv_time_nx; diff_q <= diff_nx;
      state_q <= state_nx; idx_q <= idx_nx; rd_nib_q <= rd_nib_nx; flags_q <= flags_nx;
      rd_data_q <= (flags_nx == 4'h2) ? 4'h1 : rd_nib_nx;
      saved_q   <= {14'b0, 16'(day_q), min_q, sec_q};
      busy_q    <= (state_q == CATCHUP);
      t32_q     <= bus.RTC_time[32];
      t32_qq    <= t32_q;
    end
  end

`ifdef RTC_ALARM_EN
  logic [11:0] alarm_q, alarm_nx;
  logic        irq_q, irq_nx;

  always_comb begin
    alarm_nx = alarm_q;
    irq_nx   = irq_q;
    if (cmd_en && op == 4'h7)
      for (int i = 0; i < 3; i++) if (idx_q == 8'(i)) alarm_nx[i*4 +: 4] = opd;
    if (flags_q[3] && (min_nx != min_q) && (min_nx == alarm_q)) irq_nx = 1'b1;
    if (cmd_en && op == 4'h6) irq_nx = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      alarm_q <= alarm_nx;
      irq_q   <= irq_nx;
    end
  end

  assign bus.alarm_irq = irq_q;
`else
  assign bus.alarm_irq = 1'b0;
`endif

  assign bus.rd_data          = rd_data_q;
  assign bus.rd_flags         = flags_q;
  assign bus.busy             = busy_q;
  assign bus.RTC_timestampOut = ts_q;
  assign bus.RTC_savedtimeOut = saved_q;
endmodule

// File: tb/tb_huc_rtc_engine.sv
// Directed bench for huc_rtc_engine at CLK_DIV=32; sub-second phase is aligned by index-0 writes.
module tb_huc_rtc_engine;
  logic clk_sys = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt;
  logic [47:0] st;

  huc_rtc_engine_if bus();
  huc_rtc_engine #(.CLK_DIV(32), .DAY_W(16)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cmd(input logic [7:0] b);
    bus.ce_cpu = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_di = b;
    cyc();
    bus.ce_cpu = 1'b0; bus.cmd_wr = 1'b0;
  endtask

  task automatic bk(input logic [7:0] a, input logic [15:0] d);
    bus.bk_rtc_wr = 1'b1; bus.bk_addr = a; bus.bk_data = d;
    cyc();
    bus.bk_rtc_wr = 1'b0;
  endtask

  task automatic count_busy(input int n);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.busy) busy_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.ce_cpu = 0; bus.cmd_wr = 0; bus.cmd_di = 0; bus.RTC_time = '0;
    bus.bk_rtc_wr = 0; bus.bk_addr = 0; bus.bk_data = 0;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_flags", bus.rd_flags, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ts", bus.RTC_timestampOut, 0);
    chk("rst_saved", bus.RTC_savedtimeOut, 0);
    chk("rst_irq", bus.alarm_irq, 0);
    reset_n = 1'b1;
    cyc();

    // min=0x21, then 59 ticks -> sec 59, 60th tick carries into min
    cmd(8'h40); cmd(8'h31); cmd(8'h32);
    repeat (1910) cyc();
    chk("t1_sec59", bus.RTC_savedtimeOut[5:0], 59);
    chk("t1_min21", bus.RTC_savedtimeOut[17:6], 12'h021);
    repeat (10) cyc();
    chk("t1_min22", bus.RTC_savedtimeOut[17:6], 12'h022);
    chk("t1_sec0", bus.RTC_savedtimeOut[5:0], 0);

    // nibble commands, min=0x5A3
    cmd(8'h40); cmd(8'h33); cmd(8'h3A); cmd(8'h35);
    cmd(8'h40); cmd(8'h10);
    chk("rd_min0", bus.rd_data, 4'h3);
    cmd(8'h10);
    chk("rd_min1", bus.rd_data, 4'hA);
    cmd(8'h10);
    chk("rd_idx2", bus.rd_data, 4'h5);
    cmd(8'h43); cmd(8'h3C); cmd(8'h43); cmd(8'h10);
    chk("rd_day0", bus.rd_data, 4'hC);
    cmd(8'h47); cmd(8'h10);
    chk("rd_out_of_range", bus.rd_data, 4'h0);
    cmd(8'h62);
    chk("flags2_rd", bus.rd_data, 4'h1);
    chk("flags2_reg", bus.rd_flags, 4'h2);
    cmd(8'h60);
    chk("flags0_reg", bus.rd_flags, 4'h0);
    cmd(8'h4F); cmd(8'h5F); cmd(8'h10); cmd(8'h10);
    chk("idx_wrap", bus.rd_data, 4'h3);
    chk("saved_min", bus.RTC_savedtimeOut[17:6], 12'h5A3);
    chk("saved_day", bus.RTC_savedtimeOut[33:18], 16'h000C);

    // catch-up: ts 1000, saved 870 -> 130 s = 2 minute + 10 second steps
    bk(8'd0, 16'h0366); bk(8'd1, 16'h0000);
    bk(8'd2, 16'h0000); bk(8'd3, 16'h0000); bk(8'd4, 16'h0000);
    cmd(8'h40); cmd(8'h20);
    bus.RTC_time = {~bus.RTC_time[32], 32'd1000};
    cyc(); cyc();
    chk("ts_loaded", bus.RTC_timestampOut, 1000);
    bk(8'd5, 16'h0000);
    chk("busy_T1", bus.busy, 0);
    count_busy(20);
    chk("cu_busy_cycles", busy_cnt, 12);
    chk("cu_time", bus.RTC_savedtimeOut, (2 << 6) | 10);
    chk("cu_ts", bus.RTC_timestampOut, 1000);
    chk("cu_busy_end", bus.busy, 0);

    // catch-up across a tick: ts 2000, saved 1870, tick lands on the 4th step cycle
    bk(8'd0, 16'h074E);
    cmd(8'h40); cmd(8'h20);
    bus.RTC_time = {~bus.RTC_time[32], 32'd2000};
    cyc(); cyc();
    repeat (25) cyc();
    bk(8'd5, 16'h0000);
    count_busy(20);
    chk("cut_busy_cycles", busy_cnt, 13);
    chk("cut_time", bus.RTC_savedtimeOut, (2 << 6) | 11);
    chk("cut_ts", bus.RTC_timestampOut, 2001);

    // day/min/sec rollover on one tick; saved ts max so no catch-up
    st = {14'b0, 16'hFFFF, 12'd1439, 6'd59};
    bk(8'd0, 16'hFFFF); bk(8'd1, 16'hFFFF);
    bk(8'd2, st[15:0]); bk(8'd3, st[31:16]); bk(8'd4, st[47:32]);
    cmd(8'h40); cmd(8'h20);
    bk(8'd5, 16'h0000);
    repeat (30) cyc();
    chk("roll_before", bus.RTC_savedtimeOut, st);
    repeat (2) cyc();
    chk("roll_after", bus.RTC_savedtimeOut, 0);
    chk("roll_busy", bus.busy, 0);

`ifdef RTC_ALARM_EN
    cmd(8'h40); cmd(8'h34);
    cmd(8'h40); cmd(8'h75); cmd(8'h68);
    cmd(8'h40); cmd(8'h35);
    chk("alarm_set", bus.alarm_irq, 1);
    cmd(8'h60);
    chk("alarm_clr", bus.alarm_irq, 0);
`else
    cmd(8'h40); cmd(8'h34);
    cmd(8'h40); cmd(8'h75); cmd(8'h68);
    cmd(8'h40); cmd(8'h35);
    chk("alarm_absent", bus.alarm_irq, 0);
    cmd(8'h60);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
